// File: rtl/muu_pkg.sv
// rtl/muu_pkg.sv - shared command field offsets, FSM encoding and burst helper for the value memory interface
package muu_pkg;

  // Command word layout: [31:0] word address, [39:32] beat count
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_LEN_LSB  = 32;
  localparam int CMD_LEN_MSB  = 39;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_CMD  = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD_CMD  = 2'd3
  } memif_state_t;

  // Length of the next burst: whatever is left, capped at the burst limit
  function automatic logic [7:0] min_burst(input logic [7:0] remaining, input logic [7:0] max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/muu_value_memif_if.sv
// rtl/muu_value_memif_if.sv - command, data and memory-port bundle for muu_value_memif
interface muu_value_memif_if #(
  parameter int MEMORY_WIDTH      = 512,
  parameter int VAL_MEMADDR_WIDTH = 21
);
  logic [39:0]                  wrcmd_data;
  logic                         wrcmd_valid;
  logic                         wrcmd_ready;
  logic [MEMORY_WIDTH-1:0]      wr_data;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [39:0]                  rdcmd_data;
  logic                         rdcmd_valid;
  logic                         rdcmd_ready;
  logic [MEMORY_WIDTH-1:0]      rd_data;
  logic                         rd_last;
  logic                         rd_valid;
  logic                         rd_ready;
  logic [VAL_MEMADDR_WIDTH-1:0] mem_cmd_addr;
  logic [7:0]                   mem_cmd_len;
  logic                         mem_cmd_write;
  logic                         mem_cmd_valid;
  logic                         mem_cmd_ready;
  logic [MEMORY_WIDTH-1:0]      mem_wr_data;
  logic                         mem_wr_valid;
  logic                         mem_wr_ready;
  logic [MEMORY_WIDTH-1:0]      mem_rd_data;
  logic                         mem_rd_valid;
  logic                         mem_rd_ready;

  // Pipeline side and value-memory controller side together
  modport master (
    output wrcmd_data, wrcmd_valid, input wrcmd_ready,
    output wr_data, wr_valid, input wr_ready,
    output rdcmd_data, rdcmd_valid, input rdcmd_ready,
    input rd_data, rd_last, rd_valid, output rd_ready,
    input mem_cmd_addr, mem_cmd_len, mem_cmd_write, mem_cmd_valid, output mem_cmd_ready,
    input mem_wr_data, mem_wr_valid, output mem_wr_ready,
    output mem_rd_data, mem_rd_valid, input mem_rd_ready
  );

  // The responder itself
  modport slave (
    input wrcmd_data, wrcmd_valid, output wrcmd_ready,
    input wr_data, wr_valid, output wr_ready,
    input rdcmd_data, rdcmd_valid, output rdcmd_ready,
    output rd_data, rd_last, rd_valid, input rd_ready,
    output mem_cmd_addr, mem_cmd_len, mem_cmd_write, mem_cmd_valid, input mem_cmd_ready,
    output mem_wr_data, mem_wr_valid, input mem_wr_ready,
    input mem_rd_data, mem_rd_valid, output mem_rd_ready
  );
endinterface

// File: rtl/muu_len_fifo.sv
// rtl/muu_len_fifo.sv - small synchronous FIFO holding per-read-command beat counts
module muu_len_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  // Pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= push_data;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign head  = mem[rptr[PW-1:0]];
endmodule

// File: rtl/muu_value_memif.sv
// rtl/muu_value_memif.sv - splits value-store commands into memory bursts; MUU_VALMEM_RD_CREDIT_EN enables read credit gating
module muu_value_memif
  import muu_pkg::*;
#(
  parameter int VAL_MEMADDR_WIDTH = 21,
  parameter int MAX_BURST         = 16,
  parameter int RD_CREDITS        = 64,
  parameter int LEN_FIFO_DEPTH    = 8
) (
  input logic              clk,
  input logic              rst,
  muu_value_memif_if.slave bus
);
  localparam logic [7:0] MAX_BURST_W = 8'(MAX_BURST);

  memif_state_t                 state_q;
  memif_state_t                 state_nxt;
  logic [VAL_MEMADDR_WIDTH-1:0] addr_q;
  logic [7:0]                   remaining_q;
  logic [7:0]                   burst_len_q;
  logic [7:0]                   beat_q;
  logic                         prio_rd_q;
  logic [7:0]                   rbeat_q;

  logic [7:0] cmd_len;
  logic       credit_ok;
  logic       cmd_valid;
  logic       cmd_fire;
  logic       wr_ready_c;
  logic       wr_fire;
  logic       wr_grant;
  logic       rd_grant;
  logic       wrcmd_ready_c;
  logic       rdcmd_ready_c;
  logic [7:0] wrcmd_len;
  logic [7:0] rdcmd_len;
  logic       rd_beat;
  logic       rd_last_c;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       unused_cmd_bits;

  assign wrcmd_len = bus.wrcmd_data[CMD_LEN_MSB:CMD_LEN_LSB];
  assign rdcmd_len = bus.rdcmd_data[CMD_LEN_MSB:CMD_LEN_LSB];
  assign unused_cmd_bits = ^{bus.wrcmd_data[31:VAL_MEMADDR_WIDTH], bus.rdcmd_data[31:VAL_MEMADDR_WIDTH]};

  assign cmd_len = min_burst(remaining_q, MAX_BURST_W);

  // Idle arbitration: the side holding priority wins a tie; a read is only
  // eligible while its length can still be tracked for rd_last
  assign wrcmd_ready_c = (state_q == ST_IDLE) && (!prio_rd_q || !(bus.rdcmd_valid && !fifo_full));
  assign rdcmd_ready_c = (state_q == ST_IDLE) && !fifo_full && (prio_rd_q || !bus.wrcmd_valid);
  assign wr_grant      = bus.wrcmd_valid && wrcmd_ready_c;
  assign rd_grant      = bus.rdcmd_valid && rdcmd_ready_c;

  assign cmd_valid  = (state_q == ST_WR_CMD) || ((state_q == ST_RD_CMD) && credit_ok);
  assign cmd_fire   = cmd_valid && bus.mem_cmd_ready;
  assign wr_ready_c = (state_q == ST_WR_DATA) && bus.mem_wr_ready;
  assign wr_fire    = bus.wr_valid && wr_ready_c;

  assign bus.wrcmd_ready   = wrcmd_ready_c;
  assign bus.rdcmd_ready   = rdcmd_ready_c;
  assign bus.mem_cmd_valid = cmd_valid;
  assign bus.mem_cmd_addr  = addr_q;
  assign bus.mem_cmd_len   = cmd_len;
  assign bus.mem_cmd_write = (state_q == ST_WR_CMD);
  assign bus.mem_wr_data   = bus.wr_data;
  assign bus.mem_wr_valid  = (state_q == ST_WR_DATA) && bus.wr_valid;
  assign bus.wr_ready      = wr_ready_c;

  // Return path: beats only move while a command length is known, so rd_valid
  // is gated the same way as mem_rd_ready to keep both handshakes in lockstep
  assign rd_beat          = bus.mem_rd_valid && bus.rd_ready && !fifo_empty;
  assign rd_last_c        = !fifo_empty && (rbeat_q == fifo_head - 8'd1);
  assign bus.rd_data      = bus.mem_rd_data;
  assign bus.rd_valid     = bus.mem_rd_valid && !fifo_empty;
  assign bus.mem_rd_ready = bus.rd_ready && !fifo_empty;
  assign bus.rd_last      = rd_last_c;

`ifdef MUU_VALMEM_RD_CREDIT_EN
  logic [15:0] outstanding_q;
  logic        rd_issue;

  assign rd_issue  = cmd_fire && (state_q == ST_RD_CMD);
  assign credit_ok = (outstanding_q + 16'(cmd_len)) <= 16'(RD_CREDITS);

  // Beats requested from memory but not yet handed to the consumer
  always_ff @(posedge clk) begin
    if (rst) outstanding_q <= '0;
    else     outstanding_q <= outstanding_q + (rd_issue ? 16'(cmd_len) : 16'd0) - (rd_beat ? 16'd1 : 16'd0);
  end
`else
  localparam int UNUSED_RD_CREDITS = RD_CREDITS;
  assign credit_ok = 1'b1;
`endif

  // Next-state logic of the command splitter
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_grant && wrcmd_len != 8'd0)      state_nxt = ST_WR_CMD;
        else if (rd_grant && rdcmd_len != 8'd0) state_nxt = ST_RD_CMD;
      end
      ST_WR_CMD: begin
        if (cmd_fire) state_nxt = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (wr_fire && beat_q == burst_len_q - 8'd1)
          state_nxt = (remaining_q != 8'd0) ? ST_WR_CMD : ST_IDLE;
      end
      ST_RD_CMD: begin
        if (cmd_fire && remaining_q == cmd_len) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus command address/length bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_len_q <= '0;
      beat_q      <= '0;
      prio_rd_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (wr_grant || rd_grant) begin
        prio_rd_q   <= !prio_rd_q;
        addr_q      <= wr_grant ? bus.wrcmd_data[CMD_ADDR_LSB +: VAL_MEMADDR_WIDTH]
                                : bus.rdcmd_data[CMD_ADDR_LSB +: VAL_MEMADDR_WIDTH];
        remaining_q <= wr_grant ? wrcmd_len : rdcmd_len;
      end
      if (cmd_fire) begin
        addr_q      <= addr_q + VAL_MEMADDR_WIDTH'(cmd_len);
        remaining_q <= remaining_q - cmd_len;
        burst_len_q <= cmd_len;
        beat_q      <= '0;
      end
      if (wr_fire) beat_q <= beat_q + 8'd1;
    end
  end

  // Position of the returning beat within the current read command
  always_ff @(posedge clk) begin
    if (rst)          rbeat_q <= '0;
    else if (rd_beat) rbeat_q <= rd_last_c ? 8'd0 : rbeat_q + 8'd1;
  end

  muu_len_fifo #(
    .WIDTH (8),
    .DEPTH (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_grant && rdcmd_len != 8'd0),
    .push_data (rdcmd_len),
    .pop       (rd_beat && rd_last_c),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule
